// File: rtl/bcd_countdown_timer.sv
// Three-digit BCD countdown timer with an internal tick prescaler and a
// run/pause/expire state machine driving display digits and an expiry pulse.
module bcd_countdown_timer #(
  parameter int unsigned TICK_DIV = 31_500_000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        loadN,
  input  logic        start,
  input  logic        pause,
  input  logic [11:0] datain,
  output logic [11:0] count,
  output logic        tc,
  output logic        running,
  output logic        expired
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, EXPIRED} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [11:0]   count_n;
  logic          expired_n;

  // Out-of-range preset digits saturate to 9 so the display never shows junk.
  function automatic logic [11:0] clamp_bcd(input logic [11:0] d);
    logic [11:0] r;
    r = d;
    for (int i = 0; i < 3; i++) begin
      if (d[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Only called with a nonzero value, so the hundreds borrow never underflows.
  function automatic logic [11:0] bcd_dec(input logic [11:0] c);
    logic [3:0] h, t, u;
    {h, t, u} = c;
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values and simulation matches the synthesized registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      count   <= 12'h000;
      presc   <= '0;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      presc   <= presc_n;
      running <= (state_n == RUNNING);
      expired <= expired_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    count_n   = count;
    presc_n   = presc;
    expired_n = 1'b0;
    if (!loadN) begin
      count_n = clamp_bcd(datain);
      state_n = IDLE;
      presc_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && count != 12'h000) begin
            state_n = RUNNING;
            presc_n = '0;
          end
        end
        RUNNING: begin
          if (pause) begin
            state_n = PAUSED;
          end else if (presc == PRESC_MAX) begin
            presc_n = '0;
            if (count != 12'h000) begin
              count_n = bcd_dec(count);
              if (count == 12'h001) begin
                state_n   = EXPIRED;
                expired_n = 1'b1;
              end
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        PAUSED: begin
          if (start && !pause) state_n = RUNNING;
        end
        EXPIRED: begin
          state_n = EXPIRED;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    tc = (count == 12'h000);
  end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer with TICK_DIV = 4: vector table
// plus hand-written multi-cycle sequences, all compared through a scoreboard.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        loadN;
  logic        start;
  logic        pause;
  logic [11:0] datain;
  logic [11:0] count;
  logic        tc;
  logic        running;
  logic        expired;
  bit          clk_on = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        l_n;
    logic        st;
    logic        pa;
    logic [11:0] din;
    logic [11:0] exp_count;
    logic        exp_running;
    logic        exp_expired;
    string       name;
  } vec_t;

  typedef struct {
    logic [11:0] count;
    logic        tc;
    logic        running;
    logic        expired;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];

  bcd_countdown_timer #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .resetN  (resetN),
    .loadN   (loadN),
    .start   (start),
    .pause   (pause),
    .datain  (datain),
    .count   (count),
    .tc      (tc),
    .running (running),
    .expired (expired)
  );

  initial begin
    wait (clk_on);
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, want);
    end
  endtask

  function automatic vec_t mk(input logic l_n, input logic st, input logic pa,
                              input logic [11:0] din, input logic [11:0] c,
                              input logic r, input logic x, input string name);
    vec_t v;
    v = '{l_n: l_n, st: st, pa: pa, din: din, exp_count: c,
          exp_running: r, exp_expired: x, name: name};
    return v;
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    loadN  = v.l_n;
    start  = v.st;
    pause  = v.pa;
    datain = v.din;
    e = '{count: v.exp_count, tc: (v.exp_count == 12'h000),
          running: v.exp_running, expired: v.exp_expired, name: v.name};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".count"}, count, e.count);
    check1({e.name, ".tc"}, tc, e.tc);
    check1({e.name, ".running"}, running, e.running);
    check1({e.name, ".expired"}, expired, e.expired);
  endtask

  task automatic idle(input logic [11:0] c, input logic r, input logic x, input string name);
    step(mk(1'b1, 1'b0, 1'b0, 12'h000, c, r, x, name));
  endtask

  logic [11:0] borrow_seq [7];

  initial begin
    resetN = 1'b0;
    loadN  = 1'b1;
    start  = 1'b0;
    pause  = 1'b0;
    datain = 12'h000;
    #3;
    check("reset.count", count, 12'h000);
    check1("reset.tc", tc, 1'b1);
    check1("reset.running", running, 1'b0);
    check1("reset.expired", expired, 1'b0);

    clk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // Expiry, then load priority and zero load, as a vector table.
    vecs.push_back(mk(0, 0, 0, 12'h002, 12'h002, 0, 0, "exp_load"));
    vecs.push_back(mk(1, 1, 0, 12'h000, 12'h002, 1, 0, "exp_start"));
    for (int i = 1; i <= 3; i++) vecs.push_back(mk(1, 0, 0, 12'h000, 12'h002, 1, 0, "exp_wait1"));
    vecs.push_back(mk(1, 0, 0, 12'h000, 12'h001, 1, 0, "exp_k4"));
    for (int i = 5; i <= 7; i++) vecs.push_back(mk(1, 0, 0, 12'h000, 12'h001, 1, 0, "exp_wait2"));
    vecs.push_back(mk(1, 0, 0, 12'h000, 12'h000, 0, 1, "exp_k8"));
    vecs.push_back(mk(1, 1, 0, 12'h000, 12'h000, 0, 0, "exp_k9_start"));
    vecs.push_back(mk(1, 0, 1, 12'h000, 12'h000, 0, 0, "exp_pause"));
    vecs.push_back(mk(1, 1, 0, 12'h000, 12'h000, 0, 0, "exp_restart"));
    vecs.push_back(mk(0, 0, 0, 12'h005, 12'h005, 0, 0, "lp_load"));
    vecs.push_back(mk(1, 1, 0, 12'h000, 12'h005, 1, 0, "lp_start"));
    vecs.push_back(mk(1, 0, 0, 12'h000, 12'h005, 1, 0, "lp_run1"));
    vecs.push_back(mk(1, 0, 0, 12'h000, 12'h005, 1, 0, "lp_run2"));
    vecs.push_back(mk(0, 1, 0, 12'hFAB, 12'h999, 0, 0, "lp_load_fab"));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 0, 0, 12'h000, 12'h999, 0, 0, "lp_hold"));
    vecs.push_back(mk(0, 0, 0, 12'h000, 12'h000, 0, 0, "zero_load"));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 12'h000, 12'h000, 0, 0, "zero_start"));

    foreach (vecs[i]) step(vecs[i]);

    // Borrow chain across both digit boundaries.
    borrow_seq = '{12'h105, 12'h104, 12'h103, 12'h102, 12'h101, 12'h100, 12'h099};
    step(mk(0, 0, 0, 12'h105, 12'h105, 0, 0, "bc_load"));
    step(mk(1, 1, 0, 12'h000, 12'h105, 1, 0, "bc_start"));
    for (int i = 1; i <= 24; i++) idle(borrow_seq[i / 4], 1'b1, 1'b0, "bc_run");

    // Pause/resume keeps the partial prescaler period.
    step(mk(0, 0, 0, 12'h010, 12'h010, 0, 0, "pr_load"));
    step(mk(1, 1, 0, 12'h000, 12'h010, 1, 0, "pr_start"));
    idle(12'h010, 1'b1, 1'b0, "pr_k1");
    idle(12'h010, 1'b1, 1'b0, "pr_k2");
    for (int i = 0; i < 10; i++) step(mk(1, 0, 1, 12'h000, 12'h010, 0, 0, "pr_paused"));
    step(mk(1, 1, 0, 12'h000, 12'h010, 1, 0, "pr_resume"));
    idle(12'h010, 1'b1, 1'b0, "pr_r1");
    idle(12'h009, 1'b1, 1'b0, "pr_r2");
    step(mk(1, 1, 1, 12'h000, 12'h009, 0, 0, "pr_both"));
    for (int i = 0; i < 5; i++) idle(12'h009, 1'b0, 1'b0, "pr_frozen");

    // Asynchronous reset mid-run, away from any clock edge.
    step(mk(0, 0, 0, 12'h001, 12'h001, 0, 0, "ar_load"));
    step(mk(1, 1, 0, 12'h000, 12'h001, 1, 0, "ar_start"));
    idle(12'h001, 1'b1, 1'b0, "ar_run");
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    check("ar.count", count, 12'h000);
    check1("ar.tc", tc, 1'b1);
    check1("ar.running", running, 1'b0);
    check1("ar.expired", expired, 1'b0);
    @(negedge clk);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) idle(12'h000, 1'b0, 1'b0, "ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
